kv_lookup_ctrl: RTL

KV_LOOKUP_CTRL -- requirements
Module: kv_lookup_ctrl

---
 rtl/kv_lookup_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/kv_lookup_ctrl.sv
// Key/value lookup controller: two-level hash probe (hash-1, then hash-2) followed by a value-RAM read.
// Optional statistics counters are enabled with the KV_LOOKUP_STATS_EN macro.
`timescale 1ns/1ps
module kv_lookup_ctrl #(
   parameter int RAM_WIDTH     = 32,
   parameter int RAM_ADDR_BITS = 9,
   parameter int KEY_WIDTH     = 32,
   parameter int H1_DEPTH      = 5,
   parameter int H2_DEPTH      = 10
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [KEY_WIDTH-1:0]     req_key,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic                     rsp_hit,
   output logic [RAM_WIDTH-1:0]     rsp_value,
   output logic [RAM_ADDR_BITS-1:0] rsp_addr,
   output logic                     h1_en,
   output logic [RAM_ADDR_BITS-1:0] h1_addr,
   input  logic [RAM_WIDTH-1:0]     h1_rdata,
   output logic                     h2_en,
   output logic [RAM_ADDR_BITS-1:0] h2_addr,
   input  logic [RAM_WIDTH-1:0]     h2_rdata,
   output logic                     val_en,
   output logic [RAM_ADDR_BITS-1:0] val_addr,
   input  logic [RAM_WIDTH-1:0]     val_rdata,
   output logic [15:0]              hit_count,
   output logic [15:0]              miss_count
);

   typedef enum logic [2:0] {
      IDLE, H1_RD, H1_CHK, H2_RD, H2_CHK, VAL_RD, VAL_CHK, RESP
   } state_t;

   localparam logic [KEY_WIDTH-1:0] H1_MOD = KEY_WIDTH'(H1_DEPTH);
   localparam logic [KEY_WIDTH-1:0] H2_MOD = KEY_WIDTH'(H2_DEPTH);

   state_t                   state_q, state_d;
   logic [RAM_ADDR_BITS-1:0] h1_addr_q, h1_addr_d;
   logic [RAM_ADDR_BITS-1:0] h2_addr_q, h2_addr_d;
   logic [RAM_ADDR_BITS-1:0] val_addr_q, val_addr_d;
   logic                     rsp_hit_q, rsp_hit_d;
   logic [RAM_WIDTH-1:0]     rsp_value_q, rsp_value_d;
   logic [RAM_ADDR_BITS-1:0] rsp_addr_q, rsp_addr_d;

   function automatic logic [RAM_ADDR_BITS-1:0] hash_mod(input logic [KEY_WIDTH-1:0] key,
                                                         input logic [KEY_WIDTH-1:0] modulus);
      return RAM_ADDR_BITS'(key % modulus);
   endfunction

   always_comb begin
      state_d     = state_q;
      h1_addr_d   = h1_addr_q;
      h2_addr_d   = h2_addr_q;
      val_addr_d  = val_addr_q;
      rsp_hit_d   = rsp_hit_q;
      rsp_value_d = rsp_value_q;
      rsp_addr_d  = rsp_addr_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               h1_addr_d = hash_mod(req_key, H1_MOD);
               h2_addr_d = hash_mod(req_key, H2_MOD);
               state_d   = H1_RD;
            end
         end
         H1_RD:  state_d = H1_CHK;
         H1_CHK: begin
            // A zero hash-1 entry means "empty slot"; only then is hash-2 probed.
            if (h1_rdata != '0) begin
               val_addr_d = h1_rdata[RAM_ADDR_BITS-1:0];
               state_d    = VAL_RD;
            end else begin
               state_d = H2_RD;
            end
         end
         H2_RD:  state_d = H2_CHK;
         H2_CHK: begin
            if (h2_rdata != '0) begin
               val_addr_d = h2_rdata[RAM_ADDR_BITS-1:0];
               state_d    = VAL_RD;
            end else begin
               rsp_hit_d   = 1'b0;
               rsp_value_d = '0;
               rsp_addr_d  = '0;
               state_d     = RESP;
            end
         end
         VAL_RD: state_d = VAL_CHK;
         VAL_CHK: begin
            rsp_value_d = val_rdata;
            rsp_hit_d   = 1'b1;
            rsp_addr_d  = val_addr_q;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         h1_addr_q   <= '0;
         h2_addr_q   <= '0;
         val_addr_q  <= '0;
         rsp_hit_q   <= 1'b0;
         rsp_value_q <= '0;
         rsp_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         h1_addr_q   <= h1_addr_d;
         h2_addr_q   <= h2_addr_d;
         val_addr_q  <= val_addr_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_value_q <= rsp_value_d;
         rsp_addr_q  <= rsp_addr_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign h1_en     = (state_q == H1_RD);
   assign h2_en     = (state_q == H2_RD);
   assign val_en    = (state_q == VAL_RD);
   assign h1_addr   = h1_addr_q;
   assign h2_addr   = h2_addr_q;
   assign val_addr  = val_addr_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_value = rsp_value_q;
   assign rsp_addr  = rsp_addr_q;

`ifdef KV_LOOKUP_STATS_EN
   logic [15:0] hit_count_q, hit_count_d;
   logic [15:0] miss_count_q, miss_count_d;

   function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
      return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   endfunction

   // Counters only advance on the response handshake, so an aborted lookup never counts.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (state_q == RESP && rsp_ready) begin
         if (rsp_hit_q) hit_count_d  = sat_inc(hit_count_q);
         else           miss_count_d = sat_inc(miss_count_q);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule
